// File: rtl/memory_arbiter_pkg.sv
// Shared types and default widths for the I/D line-fill memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 26;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [2:0] {
    IDLE, D_WB, D_FILL, I_FILL, DONE_D, DONE_I
  } arb_state_e;

  typedef enum logic {REQ_I, REQ_D} req_id_e;
endpackage

// File: rtl/memory_arbiter_if.sv
// Line-wide memory port: arbiter drives the request side, memory answers with rdata/ready.
interface memory_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates I-cache fills and D-cache (writeback+)fills onto one memory port.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests (default: D wins).
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqI_mem,
  input  logic [ADDR_W-1:0] reqAddrI_mem,
  input  logic              reqD_mem,
  input  logic              reqD_cache_write,
  input  logic [ADDR_W-1:0] reqAddrD_mem,
  input  logic [ADDR_W-1:0] reqAddrD_write_mem,
  input  logic [LINE_W-1:0] data_to_mem,
  output logic [LINE_W-1:0] line_data,
  output logic              read_ready_I,
  output logic              read_ready_D,
  output logic              written_data_ack,
  output logic              arb_busy,
  memory_arbiter_if.master  mem
);
  arb_state_e        state_q, state_d;
  req_id_e           last_q, last_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d, mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d, line_q, line_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              rdy_i_q, rdy_i_d, rdy_d_q, rdy_d_d, ack_q, ack_d;
  logic              pick_d;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = reqD_mem && (!reqI_mem || last_q == REQ_I);
`else
    pick_d = reqD_mem;
`endif
    state_d     = state_q;
    last_d      = last_q;
    fill_addr_d = fill_addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    line_d      = line_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    rdy_i_d     = 1'b0;
    rdy_d_d     = 1'b0;
    ack_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          last_d      = REQ_D;
          fill_addr_d = reqAddrD_mem;
          mem_wdata_d = data_to_mem;
          mem_req_d   = 1'b1;
          mem_we_d    = reqD_cache_write;
          mem_addr_d  = reqD_cache_write ? reqAddrD_write_mem : reqAddrD_mem;
          state_d     = reqD_cache_write ? D_WB : D_FILL;
        end else if (reqI_mem) begin
          last_d     = REQ_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = reqAddrI_mem;
          state_d    = I_FILL;
        end
      end
      D_WB: if (mem.mem_ready) begin
        // mem_req stays up; the fill follows directly with the latched address
        ack_d      = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = fill_addr_q;
        state_d    = D_FILL;
      end
      D_FILL: if (mem.mem_ready) begin
        line_d    = mem.mem_rdata;
        mem_req_d = 1'b0;
        rdy_d_d   = 1'b1;
        state_d   = DONE_D;
      end
      I_FILL: if (mem.mem_ready) begin
        line_d    = mem.mem_rdata;
        mem_req_d = 1'b0;
        rdy_i_d   = 1'b1;
        state_d   = DONE_I;
      end
      DONE_D, DONE_I: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= REQ_D;
      fill_addr_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      line_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      rdy_i_q     <= 1'b0;
      rdy_d_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      fill_addr_q <= fill_addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      line_q      <= line_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      rdy_i_q     <= rdy_i_d;
      rdy_d_q     <= rdy_d_d;
      ack_q       <= ack_d;
    end
  end

  assign mem.mem_req       = mem_req_q;
  assign mem.mem_we        = mem_we_q;
  assign mem.mem_addr      = mem_addr_q;
  assign mem.mem_wdata     = mem_wdata_q;
  assign line_data         = line_q;
  assign read_ready_I      = rdy_i_q;
  assign read_ready_D      = rdy_d_q;
  assign written_data_ack  = ack_q;
  assign arb_busy          = (state_q != IDLE);
endmodule
